norm_round_unit: RTL and testbench

Post-add normalize-and-round stage for the floating-point adder datapath. It consumes the carry and 25-bit mantissa sum produced by the mantissa adder, along with the result exponent and sticky bit. It normalizes the sum with an iterative one-bit-per-cycle shifter, rounds to nearest-even, and emits a packed exponent/fraction pair for the FP32 result assembler. The block is multi-cycle and uses a valid/ready handshake on both sides.

---
 rtl/norm_round_unit.sv | 141 ++++++++++++++
 tb/tb_norm_round_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/norm_round_unit.sv
// norm_round_unit: post-add normalize and round-to-nearest-even stage of the
// FP adder datapath. The block takes a carry and mantissa sum, shifts it left
// one bit per cycle until it is normalized, rounds it, and then holds a packed
// exponent/fraction result behind a valid/ready handshake.
module norm_round_unit #(
  parameter int SIZE_DATA = 25,
  parameter int SIZE_EXP  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_carry,
  input  logic [SIZE_DATA-1:0] i_sum,
  input  logic                 i_sticky,
  input  logic [SIZE_EXP-1:0]  i_exp,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_EXP-1:0]  o_exp,
  output logic [SIZE_DATA-3:0] o_frac,
  output logic                 o_zero,
  output logic                 o_overflow
);

  // The exponent carries one extra bit so that the overflow compare cannot wrap.
  localparam int EW = SIZE_EXP + 1;
  localparam logic [EW-1:0] EXP_ONE = EW'(1);
  localparam logic [EW-1:0] EXP_MAX = {1'b0, {SIZE_EXP{1'b1}}};

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t               state, state_nxt;
  logic [SIZE_DATA-1:0] m;
  logic [EW-1:0]        e;
  logic                 s;

  logic [EW-1:0]        e_base;
  logic                 norm_stop;
  logic                 round_up;
  logic [SIZE_DATA-1:0] inc;
  logic [SIZE_DATA-1:0] m_rnd;
  logic [EW-1:0]        e_rnd;

  assign o_ready = (state == IDLE);

  // A denormal input (exponent 0) is handled as exponent 1 with hidden bit 0.
  assign e_base = (i_exp == '0) ? EXP_ONE : {1'b0, i_exp};

  // Stop shifting at zero, when normalized, or when the minimum exponent is reached.
  assign norm_stop = (m == '0) || m[SIZE_DATA-1] || (e == EXP_ONE);

  // Round-to-nearest-even on m[24:1]. The guard is m[0] and the LSB is m[1].
  always_comb begin
    // NOTE: assigning every always_comb output first, on every path, keeps
    // synthesis from inferring latches.
    round_up = m[0] & (s | m[1]);
    inc      = {1'b0, m[SIZE_DATA-1:1]} + SIZE_DATA'(round_up);
    m_rnd    = {inc[SIZE_DATA-2:0], m[0]};
    e_rnd    = e;
    if (inc[SIZE_DATA-1]) begin
      m_rnd = {1'b1, {(SIZE_DATA-2){1'b0}}, m[0]};
      e_rnd = e + EXP_ONE;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of statement order.
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (i_valid)   state_nxt = NORM;
      NORM:  if (norm_stop) state_nxt = ROUND;
      ROUND:                state_nxt = DONE;
      DONE:  if (i_ready)   state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Working registers and result registers. The results load when DONE is entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      m          <= '0;
      e          <= '0;
      s          <= 1'b0;
      o_valid    <= 1'b0;
      o_exp      <= '0;
      o_frac     <= '0;
      o_zero     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            if (i_carry) begin
              m <= {1'b1, i_sum[SIZE_DATA-1:1]};
              s <= i_sticky | i_sum[0];
              e <= e_base + EXP_ONE;
            end else begin
              m <= i_sum;
              s <= i_sticky;
              e <= e_base;
            end
          end
        end
        NORM: begin
          if (!norm_stop) begin
            m <= {m[SIZE_DATA-2:0], 1'b0};
            e <= e - EXP_ONE;
          end
        end
        ROUND: begin
          m       <= m_rnd;
          e       <= e_rnd;
          o_valid <= 1'b1;
          o_zero  <= (m_rnd[SIZE_DATA-1:1] == '0) & ~m_rnd[SIZE_DATA-1];
          if (e_rnd >= EXP_MAX) begin
            o_overflow <= 1'b1;
            o_exp      <= {SIZE_EXP{1'b1}};
            o_frac     <= '0;
          end else begin
            o_overflow <= 1'b0;
            o_exp      <= m_rnd[SIZE_DATA-1] ? e_rnd[SIZE_EXP-1:0] : '0;
            o_frac     <= m_rnd[SIZE_DATA-2:1];
          end
        end
        DONE: begin
          if (i_ready) o_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_round_unit.sv
// tb_norm_round_unit: directed vector bench for norm_round_unit. It covers result
// values, latency, handshake hold behaviour and reset in the middle of an operation.
module tb_norm_round_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_carry;
  logic [24:0] i_sum;
  logic        i_sticky;
  logic [7:0]  i_exp;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_exp;
  logic [22:0] o_frac;
  logic        o_zero;
  logic        o_overflow;

  int n_checks = 0;
  int n_errors = 0;

  norm_round_unit dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_carry    (i_carry),
    .i_sum      (i_sum),
    .i_sticky   (i_sticky),
    .i_exp      (i_exp),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_exp      (o_exp),
    .o_frac     (o_frac),
    .o_zero     (o_zero),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic        carry;
    logic [24:0] sum;
    logic        sticky;
    logic [7:0]  exp_in;
    logic [7:0]  exp_out;
    logic [22:0] frac_out;
    logic        zero_out;
    logic        ovf_out;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, and outputs are sampled there too.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present one operand for a single accepting edge. The cycle count runs from that edge.
  task automatic issue(input logic c, input logic [24:0] sm, input logic st, input logic [7:0] ex);
    i_carry  = c;
    i_sum    = sm;
    i_sticky = st;
    i_exp    = ex;
    i_valid  = 1'b1;
    step();
    i_valid  = 1'b0;
  endtask

  // Wait for o_valid. Gives the number of cycles after acceptance, or -1 on timeout.
  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      if (o_valid) begin
        cyc = i - 1;
        break;
      end
      step();
    end
    if (cyc < 0 && o_valid) cyc = 40;
  endtask

  initial begin
    int cyc;
    logic [7:0]  held_exp;
    logic [22:0] held_frac;
    logic        stable;
    logic        leaked;

    //        name         carry sum          stk exp   exp_o  frac_o        z  ov lat
    vecs[0]  = '{"carry",    1, 25'h0000000, 0, 8'd127, 8'd128, 23'h000000, 0, 0, 2};
    vecs[1]  = '{"longshift",0, 25'h0000002, 0, 8'd127, 8'd104, 23'h000000, 0, 0, 25};
    vecs[2]  = '{"rnd_carry",0, 25'h1FFFFFF, 0, 8'd127, 8'd128, 23'h000000, 0, 0, 2};
    vecs[3]  = '{"tie_even", 0, 25'h1000001, 0, 8'd127, 8'd127, 23'h000000, 0, 0, 2};
    vecs[4]  = '{"tie_stk",  0, 25'h1000001, 1, 8'd127, 8'd127, 23'h000001, 0, 0, 2};
    vecs[5]  = '{"overflow", 1, 25'h0000000, 0, 8'd254, 8'd255, 23'h000000, 0, 1, 2};
    vecs[6]  = '{"zero",     0, 25'h0000000, 0, 8'd100, 8'd0,   23'h000000, 1, 0, 2};
    vecs[7]  = '{"denorm",   0, 25'h0000100, 0, 8'd3,   8'd0,   23'h000200, 0, 0, 4};
    vecs[8]  = '{"den_rndup",0, 25'h0FFFFFF, 0, 8'd1,   8'd1,   23'h000000, 0, 0, 2};
    vecs[9]  = '{"one_shift",0, 25'h0800000, 0, 8'd127, 8'd126, 23'h000000, 0, 0, 3};
    vecs[10] = '{"exp0_in",  0, 25'h0400000, 0, 8'd0,   8'd0,   23'h200000, 0, 0, 2};
    vecs[11] = '{"carry_stk",1, 25'h0000003, 0, 8'd127, 8'd128, 23'h000001, 0, 0, 2};

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_carry = 1'b0; i_sum = '0; i_sticky = 1'b0; i_exp = '0;
    step(); step();
    i_rst = 1'b0;

    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_exp",   32'(o_exp),   32'd0);
    check("rst_frac",  32'(o_frac),  32'd0);
    check("rst_flags", {30'd0, o_zero, o_overflow}, 32'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].carry, vecs[i].sum, vecs[i].sticky, vecs[i].exp_in);
      check({vecs[i].name, "_busy"}, 32'(o_ready), 32'd0);
      wait_valid(cyc);
      check({vecs[i].name, "_lat"},  cyc,            vecs[i].lat);
      check({vecs[i].name, "_exp"},  32'(o_exp),     32'(vecs[i].exp_out));
      check({vecs[i].name, "_frac"}, 32'(o_frac),    32'(vecs[i].frac_out));
      check({vecs[i].name, "_zero"}, 32'(o_zero),    32'(vecs[i].zero_out));
      check({vecs[i].name, "_ovf"},  32'(o_overflow), 32'(vecs[i].ovf_out));
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
      check({vecs[i].name, "_drop"}, {30'd0, o_valid, o_ready}, 32'd1);
    end

    // Backpressure: hold i_ready low in DONE. A stray operand must be ignored.
    issue(1'b0, 25'h1000001, 1'b1, 8'd60);
    wait_valid(cyc);
    check("hold_lat", cyc, 2);
    held_exp  = o_exp;
    held_frac = o_frac;
    check("hold_exp0", 32'(held_exp), 32'd60);
    check("hold_frac0", 32'(held_frac), 32'd1);
    stable = 1'b1;
    i_carry = 1'b1; i_sum = 25'h0000000; i_exp = 8'd200; i_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!o_valid || o_ready || o_exp !== held_exp || o_frac !== held_frac) stable = 1'b0;
    end
    i_valid = 1'b0;
    check("hold_stable", 32'(stable), 32'd1);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check("hold_release", {30'd0, o_valid, o_ready}, 32'd1);
    leaked = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_valid) leaked = 1'b1;
    end
    check("hold_no_stray", 32'(leaked), 32'd0);

    // Reset during NORM. The in-flight operand must never appear at the output.
    issue(1'b0, 25'h0000002, 1'b0, 8'd127);
    for (int i = 0; i < 5; i++) step();
    check("mid_busy", 32'(o_ready), 32'd0);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("mid_rst_ready", 32'(o_ready), 32'd1);
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    leaked = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (o_valid || !o_ready) leaked = 1'b1;
    end
    check("mid_rst_discard", 32'(leaked), 32'd0);

    // The block still works after that reset.
    issue(1'b1, 25'h0000000, 1'b0, 8'd127);
    wait_valid(cyc);
    check("post_rst_lat", cyc, 2);
    check("post_rst_exp", 32'(o_exp), 32'd128);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
